// File: rtl/seq_prog_ctrl_if.sv
// Host/sequencer-facing bundle for the program-store controller.
// The master modport is the host+sequencer side, the slave modport is the controller.
interface seq_prog_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               load_start;
  logic [19:0]        load_data;
  logic               load_valid;
  logic               load_last;
  logic               load_ready;
  logic               run_start;
  logic               run_stop;
  logic [7:0]         next;
  logic [19:0]        inst;
  logic               inst_en;
  logic               seq_reset;
  logic [1:0]         state;
  logic [8:0]         load_count;
  logic [COUNT_W-1:0] inst_count;

  modport master (
    output load_start, load_data, load_valid, load_last,
    output run_start, run_stop, next,
    input  load_ready, inst, inst_en, seq_reset, state, load_count, inst_count
  );

  modport slave (
    input  load_start, load_data, load_valid, load_last,
    input  run_start, run_stop, next,
    output load_ready, inst, inst_en, seq_reset, state, load_count, inst_count
  );
endinterface

// File: rtl/seq_prog_ctrl.sv
// Program-store controller: 256x20 program memory loaded over a valid/ready
// stream, then replayed to the instruction sequencer one word every two cycles.
module seq_prog_ctrl #(
  parameter int PROG_DEPTH = 256,
  parameter int COUNT_W    = 16
) (
  input  logic            clock,
  input  logic            reset,
  seq_prog_ctrl_if.slave  bus
);

  // Run is split into Warm/Fetch/Exec so every output is a decode of one register.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WARM  = 3'd2,
    ST_FETCH = 3'd3,
    ST_EXEC  = 3'd4
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [8:0]         load_count_q, load_count_d;
  logic [COUNT_W-1:0] inst_count_q, inst_count_d;
  logic               inst_vld_q, inst_vld_d;
  logic [19:0]        rd_q;
  logic [19:0]        mem [PROG_DEPTH];

  logic accept;
  logic load_end;
  logic fetch_go;
  logic in_range;

  assign accept   = (fsm_q == ST_LOAD) && bus.load_valid;
  assign load_end = accept && (bus.load_last || (load_count_q == 9'(PROG_DEPTH - 1)));
  assign fetch_go = (fsm_q == ST_FETCH) && !bus.run_stop;
  // Addresses beyond the loaded program hold stale words; they issue as NO (0).
  assign in_range = ({1'b0, bus.next} < load_count_q);

  // State register and counters; reset clears everything except the memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q        <= ST_IDLE;
      load_count_q <= '0;
      inst_count_q <= '0;
      inst_vld_q   <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      load_count_q <= load_count_d;
      inst_count_q <= inst_count_d;
      inst_vld_q   <= inst_vld_d;
    end
  end

  // Next-state logic: mode transitions, load counting and issue counting.
  always_comb begin
    fsm_d        = fsm_q;
    load_count_d = load_count_q;
    inst_count_d = inst_count_q;
    inst_vld_d   = inst_vld_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          fsm_d        = ST_LOAD;
          load_count_d = '0;
        end else if (bus.run_start && (load_count_q != 9'd0)) begin
          fsm_d        = ST_WARM;
          inst_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          load_count_d = load_count_q + 9'd1;
        end
        if (load_end) begin
          fsm_d = ST_IDLE;
        end
      end
      ST_WARM: begin
        fsm_d = bus.run_stop ? ST_IDLE : ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.run_stop) begin
          fsm_d = ST_IDLE;
        end else begin
          fsm_d      = ST_EXEC;
          inst_vld_d = in_range;
          if (inst_count_q != {COUNT_W{1'b1}}) begin
            inst_count_d = inst_count_q + COUNT_W'(1);
          end
        end
      end
      ST_EXEC: begin
        fsm_d = bus.run_stop ? ST_IDLE : ST_FETCH;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // Program memory: write port for the loader, registered read port for Fetch.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[load_count_q[7:0]] <= bus.load_data;
    end
    if (fetch_go) begin
      rd_q <= mem[bus.next];
    end
  end

  assign bus.load_ready = (fsm_q == ST_LOAD);
  assign bus.inst_en    = (fsm_q == ST_EXEC);
  assign bus.seq_reset  = !((fsm_q == ST_WARM) || (fsm_q == ST_FETCH) || (fsm_q == ST_EXEC));
  assign bus.state      = (fsm_q == ST_IDLE) ? 2'd0 :
                          (fsm_q == ST_LOAD) ? 2'd1 : 2'd2;
  assign bus.inst       = inst_vld_q ? rd_q : 20'h0;
  assign bus.load_count = load_count_q;
  assign bus.inst_count = inst_count_q;

endmodule
